// File: rtl/fsm_610.sv
// fsm_610: "lanes agree" qualifier. z rises after RUN_LEN consecutive rising edges with w1 == w2.
// Defining FSM610_HIT_CNT_EN adds an 8-bit saturating count of z rising events on output hits.
module fsm_610 #(
    parameter int RUN_LEN = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       w1,
    input  logic       w2,
    output logic       z
`ifdef FSM610_HIT_CNT_EN
    ,
    output logic [7:0] hits
`endif
);

    localparam int            CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

    logic [CW-1:0] r_run;
    logic [CW-1:0] w_runNext;
    logic          w_match;

    assign w_match = ~(w1 ^ w2);

    // Resetn is active-high despite its name.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_run <= '0;
        end else begin
            r_run <= w_runNext;
        end
    end

    // Saturating match-run counter; illegal encodings above RUN_MAX fall back to S0.
    always_comb begin
        w_runNext = '0;
        if (w_match) begin
            if (r_run < RUN_MAX) begin
                w_runNext = r_run + 1'b1;
            end else if (r_run == RUN_MAX) begin
                w_runNext = RUN_MAX;
            end
        end
    end

    assign z = (r_run == RUN_MAX);

`ifdef FSM610_HIT_CNT_EN
    logic [7:0] r_hits;
    logic       w_zRise;

    assign w_zRise = (w_runNext == RUN_MAX) && (r_run != RUN_MAX);

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_hits <= '0;
        end else if (w_zRise && (r_hits != 8'hFF)) begin
            r_hits <= r_hits + 8'd1;
        end
    end

    assign hits = r_hits;
`endif

endmodule

// File: tb/tb_fsm_610.sv
// Self-checking bench for fsm_610: directed vector table, multi-cycle reset sequences, and
// randomized traffic compared against a run-length reference model. Hit counter checks need FSM610_HIT_CNT_EN.
module tb_fsm_610;

    localparam int RUN_LEN = 4;

    logic Clock;
    logic Resetn;
    logic w1;
    logic w2;
    logic z;
`ifdef FSM610_HIT_CNT_EN
    logic [7:0] hits;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: length of the current unbroken match run (not saturated at RUN_LEN).
    int modelRun  = 0;
    bit modelZ    = 0;
    int modelHits = 0;

    typedef struct {
        bit a;
        bit b;
        bit expZ;
    } vec_t;

    vec_t vecs[$];

    fsm_610 #(.RUN_LEN(RUN_LEN)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .w1    (w1),
        .w2    (w2),
        .z     (z)
`ifdef FSM610_HIT_CNT_EN
        ,
        .hits  (hits)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic void modelReset();
        modelRun  = 0;
        modelZ    = 1'b0;
        modelHits = 0;
    endfunction

    function automatic void modelStep(input bit a, input bit b);
        bit newZ;
        if (a == b) begin
            if (modelRun < 1000) modelRun++;
        end else begin
            modelRun = 0;
        end
        newZ = (modelRun >= RUN_LEN);
        if (newZ && !modelZ && modelHits < 255) modelHits++;
        modelZ = newZ;
    endfunction

    task automatic checkOutput(input string name, input bit expZ);
        checks++;
        if (z !== expZ) begin
            failures++;
            $display("[TB] FAIL %s: z=%b expected %b at %0t", name, z, expZ, $time);
        end
    endtask

`ifdef FSM610_HIT_CNT_EN
    task automatic checkHits(input string name, input int expHits);
        checks++;
        if (hits !== 8'(expHits)) begin
            failures++;
            $display("[TB] FAIL %s: hits=%0d expected %0d at %0t", name, hits, expHits, $time);
        end
    endtask
`endif

    task automatic applyStimulus(input bit a, input bit b);
        @(negedge Clock);
        w1 = a;
        w2 = b;
        @(posedge Clock);
        #1;
        modelStep(a, b);
    endtask

    // Synchronous-style reset hold; inputs parked as a mismatch at release so the idle edge stays in S0.
    task automatic resetHold();
        @(negedge Clock);
        Resetn = 1'b1;
        w1 = 1'b0;
        w2 = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_assert", 1'b0);
        repeat (2) begin
            @(posedge Clock);
            #1;
            checkOutput("reset_hold", 1'b0);
        end
`ifdef FSM610_HIT_CNT_EN
        checkHits("reset_hits", 0);
`endif
        @(negedge Clock);
        Resetn = 1'b0;
        w1 = 1'b1;
        w2 = 1'b0;
    endtask

    // Reset asserted between clock edges must clear z without waiting for a clock.
    task automatic asyncResetPulse(input string name);
        @(negedge Clock);
        #2;
        Resetn = 1'b1;
        #1;
        modelReset();
        checkOutput(name, 1'b0);
`ifdef FSM610_HIT_CNT_EN
        checkHits({name, "_hits"}, 0);
`endif
        @(negedge Clock);
        Resetn = 1'b0;
        w1 = 1'b1;
        w2 = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0;
        w1 = 1'b0;
        w2 = 1'b0;
        #1;
        Resetn = 1'b1;
        #1;
        checkOutput("reset_t0", 1'b0);

        // Directed table: basic detect + hold, restart, drop, alternating.
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        for (int r = 0; r < 3; r++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b0});
            vecs.push_back('{1'b1, 1'b0, 1'b0});
            vecs.push_back('{1'b0, 1'b1, 1'b0});
            vecs.push_back('{1'b1, 1'b1, 1'b0});
        end

        resetHold();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkOutput($sformatf("table_vec%0d", i), vecs[i].expZ);
        end

        // Asynchronous reset while sitting in S4, then a fresh run.
        resetHold();
        for (int i = 0; i < RUN_LEN; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_async_s4", 1'b1);
        asyncResetPulse("async_clear");
        for (int i = 0; i < RUN_LEN - 1; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("fresh_run_partial", 1'b0);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("fresh_run_full", 1'b1);

`ifdef FSM610_HIT_CNT_EN
        resetHold();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < RUN_LEN + 2; i++) applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        checkHits("three_runs", 3);
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < RUN_LEN; i++) applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
        end
        checkHits("saturate_255", 255);
        resetHold();
`endif

        // Randomized traffic biased towards matches, with occasional async resets.
        resetHold();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncResetPulse("rand_async_reset");
            end else begin
                bit a;
                bit m;
                a = 1'($urandom_range(0, 1));
                m = ($urandom_range(0, 9) < 8);
                applyStimulus(a, m ? a : ~a);
                checkOutput("random_z", modelZ);
`ifdef FSM610_HIT_CNT_EN
                checkHits("random_hits", modelHits);
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_610.md
# fsm_610

Sequence-detector FSM that asserts `z` once inputs `w1` and `w2` have been equal on `RUN_LEN` consecutive rising clock edges. `z` stays high for as long as the inputs keep matching. It is a Moore-style control block that sits beside the datapath as a "lanes agree" qualifier. `z` is purely a function of the registered state.

## Interface

Parameters:
- `RUN_LEN`, default 4: number of consecutive matching samples required; legal range 1..15.

Ports:
- `Clock`, input, 1: system clock; all state updates on the rising edge.
- `Resetn`, input, 1: one clock; reset is asynchronous and active-high. `Resetn`=1 clears the state immediately, independent of `Clock`. The port name is historical; polarity is active-high.
- `w1`, input, 1: first monitored input, sampled on the rising edge of `Clock`.
- `w2`, input, 1: second monitored input, sampled on the rising edge of `Clock`.
- `z`, output, 1: high when the last `RUN_LEN` samples all had `w1`==`w2`.
- `hits`, output, 8: present only with `FSM610_HIT_CNT_EN`.

## Operation

- State is a match-run counter `run`.
  - Width: ceil(log2(RUN_LEN+1)) bits.
  - Logical states S0..S`RUN_LEN`; Sk means the last k samples matched, and S0 is the reset state.
- Transition on each rising edge, with `m` = (`w1` == `w2`), i.e. XNOR:
  - `m`=0: next state is S0 from any state.
  - `m`=1 in Sk with k<`RUN_LEN`: next state is Sk+1.
  - `m`=1 in S`RUN_LEN`: stay in S`RUN_LEN`. The run saturates, so overlapping runs keep `z` high.
- Output: `z` = (`run` == `RUN_LEN`), decoded from state only. There is no combinational path from `w1`/`w2` to `z`.
- Both (0,0) and (1,1) count as matches; the specific values never matter.
- Unused counter encodings (values > `RUN_LEN`) go to S0 on the next edge and drive `z`=0.

## Timing

- Reset: while `Resetn`=1, `run`=0, `z`=0 and `hits`=0, all asynchronously.
- After reset deasserts, the first sampling edge is the first rising edge with `Resetn`=0.
- Latency:
  - `z` rises on the `RUN_LEN`-th consecutive matching edge, in the same clock-to-q as the state update.
  - `z` falls on the first mismatching edge.
- Minimum `z` pulse is one clock period.
- A mismatch during the run restarts the count from zero; the next match moves to S1.
- Reset asserted mid-run clears `z` at once. A new run needs `RUN_LEN` fresh matches after release.
- Inputs must meet setup/hold relative to `Clock`; no internal synchronizers.

## Configuration

- `FSM610_HIT_CNT_EN` defined:
  - Adds output `hits` (8 bits), incremented on each edge where `z` transitions 0→1.
  - Saturates at 255.
  - Cleared by reset.
- Not defined: the `hits` port and its logic are absent; all other behaviour is identical.

## Test plan

- Reset: hold `Resetn`=1 for 2 edges with `w1`=`w2`=0 → `z`=0 throughout. Assert `Resetn` asynchronously between edges while in S4 → `z` drops immediately.
- Basic detect (`RUN_LEN`=4): (0,0),(1,1),(0,0),(1,1) on edges 1–4 → `z`=0 after edges 1–3, `z`=1 after edge 4. Hold (1,1) three more edges → `z` stays 1.
- Restart: three matches, then (1,0), then four matches → `z`=0 through edge 7, `z`=1 after edge 8.
- Drop: in S4, apply (0,1) → `z`=0 after that edge. Apply one match → still 0 (S1).
- Alternating stimulus (0,0),(1,0),(0,1),(1,1) repeated → `z` never asserts.
- With `FSM610_HIT_CNT_EN`:
  - Three separate qualifying runs separated by mismatches → `hits`=3.
  - 300 runs → `hits`=255.
  - Reset → `hits`=0.
